frl_ckpt_ctrl: RTL and testbench
================================

// Module: frl_ckpt_ctrl
// PURPOSE
//  Branch checkpoint controller for the free register list (FRL) FIFO. Each
//  dispatched branch snapshots the FRL read pointer into an age-ordered table.
//  On mispredict, the block drives the FRL's change_r_ptr_en/change_r_ptr_value
//  to roll the pointer back, and squashes that checkpoint and all younger ones.
//  Sits between dispatch/branch-resolution and the FRL sync FIFO.
// PARAMETERS
//  PTR_WIDTH  6  FRL pointer width ((n+1)-bit form, matches FRL r_ptr)
//  NUM_CKPT   4  checkpoint entries; power of 2
//  TAG_WIDTH  2  log2(NUM_CKPT); branch tag width
// PORTS
//  clk             in   1          clock, posedge
//  reset           in   1          asynchronous, active-high
//  ckpt_req        in   1          dispatch wants a checkpoint this cycle
//  frl_r_ptr       in   PTR_WIDTH  current FRL r_ptr, sampled on grant
//  ckpt_grant      out  1          combinational; request accepted this cycle
//  ckpt_tag        out  TAG_WIDTH  combinational; tag given on grant (tail index)
//  ckpt_full       out  1          all NUM_CKPT entries allocated
//  br_valid        in   1          a branch resolves this cycle
//  br_tag          in   TAG_WIDTH  tag of resolving branch
//  br_mispredict   in   1          qualifies br_valid: 1 = mispredicted
//  change_r_ptr_en     out 1         registered; one-cycle pulse to FRL
//  change_r_ptr_value  out PTR_WIDTH registered; restored FRL r_ptr
//  flush_mask      out  NUM_CKPT   registered; one-cycle pulse, bit i = tag i squashed
//  resolve_err     out  1          registered; pulse when br_tag not live
// BEHAVIOUR
//  - State: ptr_mem[NUM_CKPT], live[NUM_CKPT], head/tail ptrs of TAG_WIDTH+1 bits
//    (MSB wrap bit). count = tail - head; ckpt_full = (count == NUM_CKPT).
//  - Reset (async): head=tail=0, live=0, all registered outputs 0; ptr_mem is
//    not reset.
//  - Grant: ckpt_grant = ckpt_req & ~ckpt_full & ~(br_valid & br_mispredict & ~err).
//    On grant: ptr_mem[tail idx] <= frl_r_ptr, live set, tail+1. ckpt_tag =
//    tail[TAG_WIDTH-1:0] whenever ckpt_req=1, regardless of grant.
//  - Live tag: live[br_tag]=1 and the tag lies between head and tail.
//    Otherwise err=1: no state change; resolve_err=1 next cycle.
//  - Correct resolve (br_valid & ~br_mispredict & live): live[br_tag]<=0. The
//    entry stays allocated until head passes it.
//  - Retire: each cycle, if count!=0 and live[head idx]==0, head+1. At most
//    one retire per cycle. This proceeds even in a cycle with a mispredict.
//  - Mispredict (br_valid & br_mispredict & live):
//    - Next cycle: change_r_ptr_en=1 and change_r_ptr_value=ptr_mem[br_tag].
//    - Next cycle: flush_mask has bits set for br_tag through tail-1, in age order.
//    - Same edge: live cleared for those entries; tail <= head + ((br_tag - head idx)
//      mod NUM_CKPT), with the wrap bit recomputed, so br_tag becomes the next tag
//      issued.
//    - The mispredict has priority over a same-cycle ckpt_req, which is not granted.
//  - Mispredict together with retire in the same cycle: the tail computation uses
//    the pre-edge head. A mispredict on the head entry leaves count=0 after the edge.
//  - Latency: grant same cycle; rollback/flush/err outputs 1 cycle after resolve.
//    The FRL applies change_r_ptr on the following edge.
//  - Wrap-around: indices are the low TAG_WIDTH bits. full vs empty is
//    distinguished by the MSB.
//  - No multi-branch resolve per cycle. Back-to-back mispredicts are legal; the
//    second one sees the state updated by the first.
// TESTING
//  - Reset mid-operation: 3 ckpts live, assert reset -> ckpt_full=0,
//    change_r_ptr_en=0, next ckpt_tag=0.
//  - Fill: 4 grants with frl_r_ptr=5,9,12,20 -> tags 0..3, ckpt_full=1. A 5th
//    req gives ckpt_grant=0.
//  - Mispredict tag1 with tags 0..3 live -> next cycle change_r_ptr_en=1,
//    value=9, flush_mask=4'b1110. Next ckpt_tag=1.
//  - Out-of-order correct resolve: resolve tag2, then tag0 -> head advances
//    0->1 only. Resolving tag1 then lets head reach 3 in 2 cycles.
//  - Wrap: allocate/retire 6 branches, then mispredict the entry at idx 1 with
//    the tail wrapped -> flush_mask covers idx 1..tail-1 modulo 4. Rollback value
//    is correct.
//  - Error/priority: br_tag not live -> resolve_err pulse, no state change.
//    Mispredict + ckpt_req same cycle -> ckpt_grant=0.

Source files
------------

// File: rtl/frl_ckpt_ctrl.sv
// frl_ckpt_ctrl: age-ordered branch checkpoints of the FRL read pointer with mispredict rollback
module frl_ckpt_ctrl #(
  parameter int PTR_WIDTH = 6,
  parameter int NUM_CKPT  = 4,
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ckpt_req,
  input  logic [PTR_WIDTH-1:0] frl_r_ptr,
  output logic                 ckpt_grant,
  output logic [TAG_WIDTH-1:0] ckpt_tag,
  output logic                 ckpt_full,
  input  logic                 br_valid,
  input  logic [TAG_WIDTH-1:0] br_tag,
  input  logic                 br_mispredict,
  output logic                 change_r_ptr_en,
  output logic [PTR_WIDTH-1:0] change_r_ptr_value,
  output logic [NUM_CKPT-1:0]  flush_mask,
  output logic                 resolve_err
);
  logic [PTR_WIDTH-1:0] r_ptr_mem [NUM_CKPT];
  logic [NUM_CKPT-1:0]  r_live, w_live_nxt, w_mask, w_tag_oh, w_new_oh;
  logic [TAG_WIDTH:0]   r_head, r_tail, w_count, w_tail_nxt;
  logic [TAG_WIDTH-1:0] w_hidx, w_off;
  logic                 w_hit, w_err, w_mis, w_ok, w_ret;

  assign w_hidx     = r_head[TAG_WIDTH-1:0];
  assign w_count    = r_tail - r_head;
  assign w_off      = br_tag - w_hidx;
  assign w_tag_oh   = NUM_CKPT'(1) << br_tag;
  assign w_new_oh   = NUM_CKPT'(1) << ckpt_tag;
  assign w_hit      = r_live[br_tag] && ({1'b0, w_off} < w_count);
  assign w_err      = br_valid & ~w_hit;
  assign w_mis      = br_valid & br_mispredict & w_hit;
  assign w_ok       = br_valid & ~br_mispredict & w_hit;
  assign w_ret      = (w_count != '0) && !r_live[w_hidx];
  assign ckpt_full  = w_count[TAG_WIDTH];
  assign ckpt_tag   = r_tail[TAG_WIDTH-1:0];
  assign ckpt_grant = ckpt_req & ~ckpt_full & ~w_mis;

  // An entry is squashed when its age offset from head is at or beyond the mispredicted tag's
  for (genvar i = 0; i < NUM_CKPT; i++) begin : g_mask
    logic [TAG_WIDTH-1:0] w_oi;
    assign w_oi      = TAG_WIDTH'(i) - w_hidx;
    assign w_mask[i] = (w_oi >= w_off) && ({1'b0, w_oi} < w_count);
  end

  assign w_tail_nxt = w_mis ? r_head + {1'b0, w_off} : r_tail + (TAG_WIDTH+1)'(ckpt_grant);
  assign w_live_nxt = (r_live & ~(w_mis ? w_mask : '0) & ~(w_ok ? w_tag_oh : '0))
                    | (ckpt_grant ? w_new_oh : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head             <= '0;
      r_tail             <= '0;
      r_live             <= '0;
      change_r_ptr_en    <= 1'b0;
      change_r_ptr_value <= '0;
      flush_mask         <= '0;
      resolve_err        <= 1'b0;
    end else begin
      r_head          <= r_head + (TAG_WIDTH+1)'(w_ret);
      r_tail          <= w_tail_nxt;
      r_live          <= w_live_nxt;
      change_r_ptr_en <= w_mis;
      if (w_mis) change_r_ptr_value <= r_ptr_mem[br_tag];
      flush_mask      <= w_mis ? w_mask : '0;
      resolve_err     <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (ckpt_grant) r_ptr_mem[ckpt_tag] <= frl_r_ptr;
  end
endmodule

// File: tb/tb_frl_ckpt_ctrl.sv
// tb_frl_ckpt_ctrl: directed stimulus with queued expectations checked by an independent monitor
module tb_frl_ckpt_ctrl;
  logic       clk = 0, reset = 1;
  logic       ckpt_req = 0, br_valid = 0, br_mispredict = 0;
  logic [5:0] frl_r_ptr = 0;
  logic [1:0] br_tag = 0;
  logic       ckpt_grant, ckpt_full, change_r_ptr_en, resolve_err;
  logic [1:0] ckpt_tag;
  logic [5:0] change_r_ptr_value;
  logic [3:0] flush_mask;
  int         n_chk = 0, n_err = 0, n_exp_err = 0;
  logic [3:0]  q_g [$];
  logic [10:0] q_rb [$];

  frl_ckpt_ctrl dut (
    .clk(clk), .reset(reset), .ckpt_req(ckpt_req), .frl_r_ptr(frl_r_ptr),
    .ckpt_grant(ckpt_grant), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
    .br_valid(br_valid), .br_tag(br_tag), .br_mispredict(br_mispredict),
    .change_r_ptr_en(change_r_ptr_en), .change_r_ptr_value(change_r_ptr_value),
    .flush_mask(flush_mask), .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_g(input logic g, input logic [1:0] t, input logic f);
    q_g.push_back({g, t, f});
  endtask

  task automatic exp_rb(input logic [5:0] v, input logic [3:0] m);
    q_rb.push_back({1'b1, v, m});
  endtask

  task automatic step(input logic rq, input logic [5:0] p, input logic bv,
                      input logic [1:0] bt, input logic bm);
    ckpt_req = rq; frl_r_ptr = p; br_valid = bv; br_tag = bt; br_mispredict = bm;
    @(posedge clk); #1;
    ckpt_req = 0; br_valid = 0; br_mispredict = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ckpt_req) begin
        if (q_g.size() == 0) chk("grant_unexpected", 16'(ckpt_grant), 16'hffff);
        else chk("grant_tag_full", 16'({ckpt_grant, ckpt_tag, ckpt_full}), 16'(q_g.pop_front()));
      end
      if (change_r_ptr_en || flush_mask != 0) begin
        if (q_rb.size() == 0) chk("rollback_unexpected", 16'({change_r_ptr_value, flush_mask}), 16'hffff);
        else chk("rollback", 16'({change_r_ptr_en, change_r_ptr_value, flush_mask}), 16'(q_rb.pop_front()));
      end
      if (resolve_err) begin
        chk("resolve_err_expected", 16'(n_exp_err > 0), 16'd1);
        if (n_exp_err > 0) n_exp_err--;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", 16'(ckpt_full), 16'd0);
    chk("rst_en", 16'({change_r_ptr_en, flush_mask, resolve_err}), 16'd0);
    reset = 0;
    // three checkpoints, then a mispredict killed by an asynchronous reset
    exp_g(1, 0, 0); step(1, 5, 0, 0, 0);
    exp_g(1, 1, 0); step(1, 6, 0, 0, 0);
    exp_g(1, 2, 0); step(1, 7, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    reset = 1; #1;
    chk("midrst_full", 16'(ckpt_full), 16'd0);
    chk("midrst_en", 16'({change_r_ptr_en, flush_mask}), 16'd0);
    @(posedge clk); #1;
    reset = 0;
    // fill
    exp_g(1, 0, 0); step(1, 5, 0, 0, 0);
    exp_g(1, 1, 0); step(1, 9, 0, 0, 0);
    exp_g(1, 2, 0); step(1, 12, 0, 0, 0);
    exp_g(1, 3, 0); step(1, 20, 0, 0, 0);
    exp_g(0, 0, 1); step(1, 33, 0, 0, 0);
    // mispredict tag1 with all live
    exp_rb(9, 4'b1110); step(0, 0, 1, 1, 1);
    exp_g(1, 1, 0); step(1, 40, 0, 0, 0);
    exp_g(1, 2, 0); step(1, 41, 0, 0, 0);
    exp_g(1, 3, 0); step(1, 42, 0, 0, 0);
    // out-of-order correct resolves
    step(0, 0, 1, 2, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    exp_g(1, 0, 0); step(1, 50, 0, 0, 0);
    exp_g(0, 1, 1); step(1, 51, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    exp_g(0, 1, 1); step(1, 52, 0, 0, 0);
    exp_g(1, 1, 0); step(1, 60, 0, 0, 0);
    exp_g(1, 2, 0); step(1, 61, 0, 0, 0);
    exp_g(0, 3, 1); step(1, 62, 0, 0, 0);
    // wrapped tail: head idx3, mispredict idx1
    exp_rb(60, 4'b0110); step(0, 0, 1, 1, 1);
    exp_g(1, 1, 0); step(1, 70, 0, 0, 0);
    // errors: tag outside window (req still granted), then resolved-but-allocated tag
    exp_g(1, 2, 0); n_exp_err++; step(1, 71, 1, 2, 1);
    step(0, 0, 1, 0, 0);
    n_exp_err++; step(0, 0, 1, 0, 1);
    // back-to-back mispredicts, second with a competing request
    exp_rb(71, 4'b0100); step(0, 0, 1, 2, 1);
    exp_g(0, 2, 0); exp_rb(70, 4'b0010); step(1, 80, 1, 1, 1);
    exp_rb(42, 4'b1001); step(0, 0, 1, 3, 1);
    // head mispredict leaves the table empty
    exp_g(1, 3, 0); step(1, 90, 0, 0, 0);
    exp_g(1, 0, 0); step(1, 91, 0, 0, 0);
    exp_g(1, 1, 0); step(1, 92, 0, 0, 0);
    exp_g(1, 2, 0); step(1, 93, 0, 0, 0);
    exp_g(0, 3, 1); step(1, 94, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    chk("grant_q_left", 16'(q_g.size()), 16'd0);
    chk("rollback_q_left", 16'(q_rb.size()), 16'd0);
    chk("err_left", 16'(n_exp_err), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
